// File: rtl/mips_multicycle_core_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, funct codes,
// ALU control encodings, FSM states and small datapath helpers.
package mips_multicycle_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } CoreState;

  function automatic logic isLegalFunct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic logic [2:0] functToAluCtl(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] signExt(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // slt compares as two's-complement; everything else wraps mod 2^32
  function automatic logic [31:0] aluOp(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] ctl);
    case (ctl)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'b0, $signed(x) < $signed(y)};
      default: return x + y;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port; the core is master, memory is slave.
interface mips_multicycle_core_if #(parameter int ADDR_W = 8);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_core_regfile.sv
// 32x32 register file: two operand reads plus a debug read, one synchronous
// write, asynchronous clear; register 0 always reads zero.
module mips_multicycle_core_regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  raddrA_i,
  input  logic [4:0]  raddrB_i,
  input  logic [4:0]  raddrDbg_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdataA_o,
  output logic [31:0] rdataB_o,
  output logic [31:0] rdataDbg_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdataA_o   = (raddrA_i   == 5'd0) ? '0 : regs_q[raddrA_i];
  assign rdataB_o   = (raddrB_i   == 5'd0) ? '0 : regs_q[raddrB_i];
  assign rdataDbg_o = (raddrDbg_i == 5'd0) ? '0 : regs_q[raddrDbg_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: one FSM, one shared ALU and a single memory
// port used for both instruction fetch and load/store.
module mips_multicycle_core
  import mips_multicycle_core_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [4:0]  DBG_REG  = 5'd2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mips_multicycle_core_if.master mem,
  output logic                   illegal,
  output logic [31:0]            dbg_pc,
  output logic [31:0]            dbg_reg_value
);

  CoreState    state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluOut_q, mdr_q;
  logic        illegal_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] immExt;
  logic [31:0] rfRdA, rfRdB, rfWdata;
  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] aluA, aluB, aluRes, memAddrFull;
  logic [2:0]  aluCtl;
  logic        unusedAddrBits;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign immExt = signExt(ir_q[15:0]);

  // Single ALU: PC+4 in FETCH, branch target in DECODE, address/addi/R-type otherwise
  always_comb begin
    aluA   = pc_q;
    aluB   = 32'd4;
    aluCtl = ALU_ADD;
    case (state_q)
      DECODE:         aluB = {immExt[29:0], 2'b00};
      MEMADR, ADDIEX: begin aluA = a_q; aluB = immExt; end
      EXEC:           begin aluA = a_q; aluB = b_q; aluCtl = functToAluCtl(funct); end
      default:        ;
    endcase
  end

  assign aluRes = aluOp(aluA, aluB, aluCtl);

  assign rfWe    = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == ADDIWB);
  assign rfWaddr = (state_q == ALUWB) ? rd : rt;
  assign rfWdata = (state_q == MEMWB) ? mdr_q : aluOut_q;

  mips_multicycle_core_regfile u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .raddrA_i   (rs),
    .raddrB_i   (rt),
    .raddrDbg_i (DBG_REG),
    .we_i       (rfWe),
    .waddr_i    (rfWaddr),
    .wdata_i    (rfWdata),
    .rdataA_o   (rfRdA),
    .rdataB_o   (rfRdB),
    .rdataDbg_o (dbg_reg_value)
  );

  // Request is gated by reset_n so it drops the instant reset asserts
  assign memAddrFull   = (state_q == FETCH) ? pc_q : aluOut_q;
  assign mem.mem_req   = reset_n && ((state_q == FETCH) || (state_q == MEMRD) ||
                                     (state_q == MEMWR));
  assign mem.mem_we    = (state_q == MEMWR);
  assign mem.mem_addr  = {memAddrFull[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = b_q;
  assign unusedAddrBits = ^{memAddrFull[31:ADDR_W], memAddrFull[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluOut_q  <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (mem.mem_ready) begin
          ir_q    <= mem.mem_rdata;
          pc_q    <= aluRes;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q      <= rfRdA;
          b_q      <= rfRdB;
          aluOut_q <= aluRes;
          case (opcode)
            OP_RTYPE: begin
              state_q   <= isLegalFunct(funct) ? EXEC : TRAP;
              illegal_q <= !isLegalFunct(funct);
            end
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_BEQ:       state_q <= BRANCH;
            OP_ADDI:      state_q <= ADDIEX;
            OP_J:         state_q <= JUMP;
            default: begin
              state_q   <= TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          aluOut_q <= aluRes;
          state_q  <= (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: if (mem.mem_ready) begin
          mdr_q   <= mem.mem_rdata;
          state_q <= MEMWB;
        end
        MEMWR: if (mem.mem_ready) state_q <= FETCH;
        EXEC, ADDIEX: begin
          aluOut_q <= aluRes;
          state_q  <= (state_q == EXEC) ? ALUWB : ADDIWB;
        end
        MEMWB, ALUWB, ADDIWB: state_q <= FETCH;
        BRANCH: begin
          if (a_q == b_q) pc_q <= aluOut_q;
          state_q <= FETCH;
        end
        JUMP: begin
          pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
          state_q <= FETCH;
        end
        TRAP:    illegal_q <= 1'b1;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign dbg_pc  = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for the multicycle core: a word-organised memory model with
// programmable wait states, hand-assembled programs and cycle-exact checks.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        illegal;
  logic [31:0] dbg_pc, dbg_reg_value;

  mips_multicycle_core_if memBus ();

  mips_multicycle_core dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (memBus),
    .illegal       (illegal),
    .dbg_pc        (dbg_pc),
    .dbg_reg_value (dbg_reg_value)
  );

  always #5 clk = ~clk;

  logic [31:0] memWords [64];
  int          waitCycles = 0;
  int          waitCnt = 0;
  int          wrCount = 0;
  int          wrBase;
  logic [31:0] lastWrAddr = 32'h0;
  logic [31:0] lastWrData = 32'h0;
  logic        clearEn = 1'b0;
  logic        loadEn = 1'b0;
  logic [5:0]  loadIdx = 6'd0;
  logic [31:0] loadData = 32'h0;
  int          checks = 0;
  int          failures = 0;

  assign memBus.mem_ready = memBus.mem_req && (waitCnt >= waitCycles);
  assign memBus.mem_rdata = memWords[memBus.mem_addr[7:2]];

  // Memory model owns memWords; the stimulus thread loads it via clearEn/loadEn
  always @(posedge clk) begin
    if (clearEn) begin
      for (int i = 0; i < 64; i++) memWords[i] <= 32'h0;
    end else if (loadEn) begin
      memWords[loadIdx] <= loadData;
    end else if (memBus.mem_req && memBus.mem_ready && memBus.mem_we) begin
      memWords[memBus.mem_addr[7:2]] <= memBus.mem_wdata;
      wrCount    <= wrCount + 1;
      lastWrAddr <= {24'h0, memBus.mem_addr};
      lastWrData <= memBus.mem_wdata;
    end
    if (memBus.mem_req && !memBus.mem_ready) waitCnt <= waitCnt + 1;
    else                                      waitCnt <= 0;
  end

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input int idx, input logic [31:0] w);
    loadIdx  = idx[5:0];
    loadData = w;
    loadEn   = 1'b1;
    applyStimulus(1);
    loadEn   = 1'b0;
  endtask

  task automatic clearMem();
    clearEn = 1'b1;
    applyStimulus(1);
    clearEn = 1'b0;
  endtask

  task automatic releaseReset();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1);

    $display("[TB] program 1: addi/addi/add");
    clearMem();
    loadWord(0, encI(6'h08, 5'd0, 5'd2, 16'd5));
    loadWord(1, encI(6'h08, 5'd0, 5'd3, 16'd7));
    loadWord(2, encR(5'd2, 5'd3, 5'd2, 6'h20));
    loadWord(3, encJ(26'd3));
    checkOutput("rst_mem_req", {31'b0, memBus.mem_req}, 32'd0);
    checkOutput("rst_pc", dbg_pc, 32'h0);
    checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
    checkOutput("rst_reg", dbg_reg_value, 32'd0);
    releaseReset();
    checkOutput("p1_first_req", {31'b0, memBus.mem_req}, 32'd1);
    checkOutput("p1_first_addr", {24'h0, memBus.mem_addr}, 32'h0);
    applyStimulus(3);
    checkOutput("p1_before_wb", dbg_reg_value, 32'd0);
    applyStimulus(1);
    checkOutput("p1_addi_wb", dbg_reg_value, 32'd5);
    applyStimulus(7);
    checkOutput("p1_cycle11", dbg_reg_value, 32'd5);
    applyStimulus(1);
    checkOutput("p1_cycle12", dbg_reg_value, 32'd12);
    checkOutput("p1_pc", dbg_pc, 32'hC);

    $display("[TB] program 2: sw/lw with 3 wait states");
    reset_n = 1'b0;
    #1;
    checkOutput("p2_rst_regs", dbg_reg_value, 32'd0);
    clearMem();
    loadWord(0, encI(6'h08, 5'd0, 5'd2, 16'd12));
    loadWord(1, encI(6'h2B, 5'd0, 5'd2, 16'h40));
    loadWord(2, encI(6'h23, 5'd0, 5'd4, 16'h40));
    loadWord(3, encR(5'd4, 5'd4, 5'd2, 6'h20));
    loadWord(4, encJ(26'd4));
    waitCycles = 3;
    wrBase = wrCount;
    releaseReset();
    applyStimulus(16);
    checkOutput("p2_no_write_yet", wrCount - wrBase, 32'd0);
    checkOutput("p2_wr_we", {31'b0, memBus.mem_we}, 32'd1);
    checkOutput("p2_wr_addr", {24'h0, memBus.mem_addr}, 32'h40);
    checkOutput("p2_wr_data", memBus.mem_wdata, 32'd12);
    applyStimulus(1);
    checkOutput("p2_write_count", wrCount - wrBase, 32'd1);
    checkOutput("p2_write_addr", lastWrAddr, 32'h40);
    checkOutput("p2_write_data", lastWrData, 32'd12);
    applyStimulus(8);
    checkOutput("p2_rd_req", {31'b0, memBus.mem_req}, 32'd1);
    checkOutput("p2_rd_we", {31'b0, memBus.mem_we}, 32'd0);
    checkOutput("p2_rd_addr", {24'h0, memBus.mem_addr}, 32'h40);
    applyStimulus(9);
    checkOutput("p2_cycle34", dbg_reg_value, 32'd12);
    applyStimulus(1);
    checkOutput("p2_lw_result", dbg_reg_value, 32'd24);

    $display("[TB] program 3: beq not taken / taken, j");
    reset_n = 1'b0;
    waitCycles = 0;
    clearMem();
    loadWord(0, encI(6'h08, 5'd0, 5'd3, 16'd1));
    loadWord(1, encI(6'h04, 5'd0, 5'd3, 16'd5));
    loadWord(2, encI(6'h08, 5'd3, 5'd3, 16'hFFFF));
    loadWord(3, encI(6'h04, 5'd0, 5'd3, 16'hFFFE));
    loadWord(4, encJ(26'h10));
    loadWord(16, encJ(26'h10));
    releaseReset();
    applyStimulus(7);
    checkOutput("p3_beq_not_taken", dbg_pc, 32'h8);
    applyStimulus(6);
    checkOutput("p3_beq_decode_pc", dbg_pc, 32'h10);
    applyStimulus(1);
    checkOutput("p3_beq_taken", dbg_pc, 32'h8);
    applyStimulus(7);
    checkOutput("p3_beq_fallthrough", dbg_pc, 32'h10);
    applyStimulus(2);
    checkOutput("p3_j_decode_pc", dbg_pc, 32'h14);
    applyStimulus(1);
    checkOutput("p3_j_target", dbg_pc, 32'h40);
    applyStimulus(3);
    checkOutput("p3_j_self", dbg_pc, 32'h40);

    $display("[TB] program 4: illegal opcode and funct");
    reset_n = 1'b0;
    clearMem();
    loadWord(0, {6'h3F, 26'h0});
    releaseReset();
    applyStimulus(1);
    checkOutput("p4_illegal_fetch", {31'b0, illegal}, 32'd0);
    applyStimulus(1);
    checkOutput("p4_illegal_set", {31'b0, illegal}, 32'd1);
    checkOutput("p4_trap_req", {31'b0, memBus.mem_req}, 32'd0);
    applyStimulus(3);
    checkOutput("p4_illegal_sticky", {31'b0, illegal}, 32'd1);
    checkOutput("p4_trap_req_held", {31'b0, memBus.mem_req}, 32'd0);
    checkOutput("p4_trap_pc", dbg_pc, 32'h4);
    reset_n = 1'b0;
    #1;
    checkOutput("p4_rst_illegal", {31'b0, illegal}, 32'd0);
    checkOutput("p4_rst_pc", dbg_pc, 32'h0);
    loadWord(0, encR(5'd1, 5'd2, 5'd3, 6'h21));
    releaseReset();
    checkOutput("p4_restart_addr", {24'h0, memBus.mem_addr}, 32'h0);
    applyStimulus(2);
    checkOutput("p4_bad_funct", {31'b0, illegal}, 32'd1);

    $display("[TB] program 5: reset during store stall");
    reset_n = 1'b0;
    clearMem();
    loadWord(0, encI(6'h2B, 5'd0, 5'd0, 16'h40));
    loadWord(16, 32'hA5A5A5A5);
    waitCycles = 5;
    wrBase = wrCount;
    releaseReset();
    applyStimulus(10);
    checkOutput("p5_stall_req", {31'b0, memBus.mem_req}, 32'd1);
    checkOutput("p5_stall_we", {31'b0, memBus.mem_we}, 32'd1);
    checkOutput("p5_stall_addr", {24'h0, memBus.mem_addr}, 32'h40);
    reset_n = 1'b0;
    #1;
    checkOutput("p5_async_req_drop", {31'b0, memBus.mem_req}, 32'd0);
    applyStimulus(2);
    checkOutput("p5_no_write", wrCount - wrBase, 32'd0);
    checkOutput("p5_mem_intact", memWords[16], 32'hA5A5A5A5);
    waitCycles = 0;
    releaseReset();
    checkOutput("p5_restart_req", {31'b0, memBus.mem_req}, 32'd1);
    checkOutput("p5_restart_addr", {24'h0, memBus.mem_addr}, 32'h0);
    applyStimulus(1);
    checkOutput("p5_restart_pc", dbg_pc, 32'h4);

    $display("[TB] program 6: $0 writes, slt signed, sub/or/and");
    reset_n = 1'b0;
    clearMem();
    loadWord(0, encI(6'h08, 5'd0, 5'd0, 16'd9));
    loadWord(1, encI(6'h08, 5'd0, 5'd6, 16'hFFFF));
    loadWord(2, encI(6'h08, 5'd0, 5'd7, 16'd1));
    loadWord(3, encR(5'd6, 5'd7, 5'd5, 6'h2A));
    loadWord(4, encR(5'd5, 5'd0, 5'd2, 6'h20));
    loadWord(5, encI(6'h2B, 5'd0, 5'd0, 16'h48));
    loadWord(6, encR(5'd7, 5'd6, 5'd2, 6'h22));
    loadWord(7, encR(5'd5, 5'd6, 5'd2, 6'h25));
    loadWord(8, encR(5'd7, 5'd2, 5'd2, 6'h24));
    loadWord(9, encJ(26'd9));
    loadWord(18, 32'hDEADBEEF);
    releaseReset();
    applyStimulus(20);
    checkOutput("p6_slt_plus_r0", dbg_reg_value, 32'd1);
    applyStimulus(4);
    checkOutput("p6_sw_r0_data", memWords[18], 32'h0);
    checkOutput("p6_sw_r0_addr", lastWrAddr, 32'h48);
    applyStimulus(4);
    checkOutput("p6_sub", dbg_reg_value, 32'd2);
    applyStimulus(4);
    checkOutput("p6_or", dbg_reg_value, 32'hFFFFFFFF);
    applyStimulus(4);
    checkOutput("p6_and", dbg_reg_value, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
